// File: rtl/ins_enc_loader_pkg.sv
// Shared definitions for the RV32I encoder/loader: class codes, major opcodes,
// immediate range limits and the signed range helper used by the packer.
package ins_enc_loader_pkg;

   typedef enum logic [3:0] {
      CL_R      = 4'd0,
      CL_I_ALU  = 4'd1,
      CL_LOAD   = 4'd2,
      CL_STORE  = 4'd3,
      CL_BRANCH = 4'd4,
      CL_JALR   = 4'd5,
      CL_JAL    = 4'd6,
      CL_AUIPC  = 4'd7,
      CL_LUI    = 4'd8
   } ins_class_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam int signed IMM12_MIN = -2048;
   localparam int signed IMM12_MAX = 2047;
   localparam int signed SHAMT_MAX = 31;
   localparam int signed BR_MIN    = -4096;
   localparam int signed BR_MAX    = 4094;
   localparam int signed JAL_MIN   = -(1 << 20);
   localparam int signed JAL_MAX   = (1 << 20) - 2;

   function automatic logic in_range(input logic signed [31:0] v,
                                     input int signed lo,
                                     input int signed hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ins_enc_loader_if.sv
// Field-bundle handshake plus IMEM write port and session status of the loader.
interface ins_enc_loader_if #(
   parameter int DEPTH = 256
) ();
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [3:0]       in_class;
   logic [4:0]       in_rd;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [2:0]       in_funct3;
   logic             in_alt;
   logic [31:0]      in_imm;
   logic             imem_we;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_wdata;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, in_valid, in_last, in_class, in_rd, in_rs1, in_rs2,
             in_funct3, in_alt, in_imm,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
   );

   modport slave (
      input  start, in_valid, in_last, in_class, in_rd, in_rs1, in_rs2,
             in_funct3, in_alt, in_imm,
      output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
   );
endinterface

// File: rtl/ins_enc_loader_ins_pack.sv
// Combinational RV32I packer: decoded fields in, 32-bit word and legality out.
module ins_pack
   import ins_enc_loader_pkg::*;
(
   input  logic [3:0]  i_class,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_alt,
   input  logic [31:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);
   logic signed [31:0] w_imm;
   assign w_imm = i_imm;

   always_comb begin
      o_word  = 32'd0;
      o_legal = 1'b0;
      case (i_class)
         CL_R: begin
            o_word  = {1'b0, i_alt, 5'd0, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            o_legal = 1'b1;
         end
         CL_I_ALU: begin
            // Shifts carry shamt in imm[4:0] and the SRAI select in bit 30
            if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
               o_word  = {1'b0, i_alt, 5'd0, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_I_ALU};
               o_legal = in_range(w_imm, 0, SHAMT_MAX);
            end else begin
               o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I_ALU};
               o_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
            end
         end
         CL_LOAD: begin
            o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            o_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
         end
         CL_JALR: begin
            o_word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
            o_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
         end
         CL_STORE: begin
            o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
            o_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
         end
         CL_BRANCH: begin
            o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], OP_BRANCH};
            o_legal = in_range(w_imm, BR_MIN, BR_MAX) && !i_imm[0];
         end
         CL_JAL: begin
            o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            o_legal = in_range(w_imm, JAL_MIN, JAL_MAX) && !i_imm[0];
         end
         CL_AUIPC: begin
            o_word  = {i_imm[31:12], i_rd, OP_AUIPC};
            o_legal = (i_imm[11:0] == 12'd0);
         end
         CL_LUI: begin
            o_word  = {i_imm[31:12], i_rd, OP_LUI};
            o_legal = (i_imm[11:0] == 12'd0);
         end
         default: begin
            o_word  = 32'd0;
            o_legal = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/ins_enc_loader.sv
// Program loader: accepts field bundles, encodes them and writes sequential
// IMEM words starting at BASE_ADDR, one registered write per good bundle.
module ins_enc_loader
   import ins_enc_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256
) (
   input logic             clk,
   input logic             rst,
   ins_enc_loader_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_next_addr;
   logic             r_err;
   logic             r_we_p1;
   logic [31:0]      r_addr_p1;
   logic [31:0]      r_wdata_p1;

   logic [31:0]      w_word;
   logic             w_legal;
   logic             w_accept;
   logic             w_full_next;

   ins_pack u_pack (
      .i_class  (bus.in_class),
      .i_rd     (bus.in_rd),
      .i_rs1    (bus.in_rs1),
      .i_rs2    (bus.in_rs2),
      .i_funct3 (bus.in_funct3),
      .i_alt    (bus.in_alt),
      .i_imm    (bus.in_imm),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   assign bus.in_ready = (r_state == S_LOAD);
   assign w_accept     = bus.in_valid && bus.in_ready;
   // This write fills the last free slot of the session
   assign w_full_next  = (r_count == CNT_W'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_next_addr <= BASE_ADDR;
         r_err       <= 1'b0;
         r_we_p1     <= 1'b0;
         r_addr_p1   <= BASE_ADDR;
         r_wdata_p1  <= 32'd0;
      end else begin
         r_we_p1 <= 1'b0;
         if (r_state == S_LOAD) begin
            if (w_accept) begin
               if (w_legal) begin
                  r_we_p1     <= 1'b1;
                  r_addr_p1   <= r_next_addr;
                  r_wdata_p1  <= w_word;
                  r_count     <= r_count + 1'b1;
                  r_next_addr <= r_next_addr + 32'd4;
                  if (bus.in_last || w_full_next) r_state <= S_DONE;
               end else begin
                  r_err <= 1'b1;
                  if (bus.in_last) r_state <= S_DONE;
               end
            end
         end else if (r_state == S_IDLE || r_state == S_DONE) begin
            if (bus.start) begin
               r_state     <= S_LOAD;
               r_count     <= '0;
               r_err       <= 1'b0;
               r_next_addr <= BASE_ADDR;
            end
         end else begin
            r_state <= S_IDLE;
         end
      end
   end

   // Output stage: registered write port and status
   assign bus.imem_we    = r_we_p1;
   assign bus.imem_addr  = r_addr_p1;
   assign bus.imem_wdata = r_wdata_p1;
   assign bus.count      = r_count;
   assign bus.busy       = (r_state == S_LOAD);
   assign bus.done       = (r_state == S_DONE);
   assign bus.err        = r_err;
endmodule

// File: tb/tb_ins_enc_loader.sv
// Directed bench for ins_enc_loader: hand-encoded RV32I words, rejects,
// session-full behaviour and mid-session reset.
module tb_ins_enc_loader;
   import ins_enc_loader_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          DEP  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   ins_enc_loader_if #(.DEPTH(DEP)) bus ();

   ins_enc_loader #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                       input logic [31:0] imm, input logic last);
      bit ok;
      ok = 1'b0;
      bus.in_class  = cls;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_alt    = alt;
      bus.in_imm    = imm;
      bus.in_last   = last;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      if (!ok) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] word);
      check({tag, "_we"}, {31'd0, bus.imem_we}, 32'd1);
      check({tag, "_addr"}, bus.imem_addr, addr);
      check({tag, "_wdata"}, bus.imem_wdata, word);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      bus.start = 0; bus.in_valid = 0; bus.in_last = 0; bus.in_class = 0;
      bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_funct3 = 0;
      bus.in_alt = 0; bus.in_imm = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_we", {31'd0, bus.imem_we}, 32'd0);
      check("rst_addr", bus.imem_addr, BASE);
      check("rst_wdata", bus.imem_wdata, 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);

      // Session 1: ALU, R-type back-to-back, LUI
      start_pulse();
      check("s1_busy", {31'd0, bus.busy}, 32'd1);
      push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
      chk_wr("addi", BASE, 32'h0050_0093);
      check("addi_count", 32'(bus.count), 32'd1);
      push(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
      chk_wr("add", BASE + 4, 32'h0020_81B3);
      push(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0);
      chk_wr("sub", BASE + 8, 32'h4020_81B3);
      push(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b1);
      chk_wr("lui", BASE + 12, 32'h1234_52B7);
      check("s1_done", {31'd0, bus.done}, 32'd1);
      idle();
      check("s1_idle_we", {31'd0, bus.imem_we}, 32'd0);

      // Session 2: store, rejects, branch, jal
      start_pulse();
      check("s2_count0", 32'(bus.count), 32'd0);
      push(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4, 1'b0);
      chk_wr("sw", BASE, 32'h0020_A223);
      idle();
      start_pulse();
      check("start_in_load_count", 32'(bus.count), 32'd1);
      check("start_in_load_busy", {31'd0, bus.busy}, 32'd1);
      push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b0);
      check("rej_addi_we", {31'd0, bus.imem_we}, 32'd0);
      check("rej_addi_err", {31'd0, bus.err}, 32'd1);
      check("rej_addi_count", 32'(bus.count), 32'd1);
      push(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0);
      check("rej_beq_we", {31'd0, bus.imem_we}, 32'd0);
      check("rej_beq_count", 32'(bus.count), 32'd1);
      push(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b0);
      chk_wr("beq", BASE + 4, 32'h0020_8463);
      push(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b1);
      chk_wr("jal", BASE + 8, 32'h0010_00EF);
      check("s2_done", {31'd0, bus.done}, 32'd1);
      check("s2_err", {31'd0, bus.err}, 32'd1);
      check("s2_count", 32'(bus.count), 32'd3);
      idle();

      // Session 3: shifts, illegal class, jalr, negative branch
      start_pulse();
      check("s3_err_clr", {31'd0, bus.err}, 32'd0);
      push(4'd1, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3, 1'b0);
      chk_wr("srai", BASE, 32'h4031_5093);
      push(4'd1, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'd32, 1'b0);
      check("rej_shamt_we", {31'd0, bus.imem_we}, 32'd0);
      check("rej_shamt_err", {31'd0, bus.err}, 32'd1);
      push(4'd9, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd0, 1'b0);
      check("rej_class_we", {31'd0, bus.imem_we}, 32'd0);
      push(4'd5, 5'd0, 5'd1, 5'd0, 3'd3, 1'b0, 32'd0, 1'b0);
      chk_wr("jalr", BASE + 4, 32'h0000_8067);
      push(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b1);
      chk_wr("beq_neg", BASE + 8, 32'hFE00_0EE3);
      idle();

      // Rejected bundle flagged last still closes the session
      start_pulse();
      push(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5001, 1'b1);
      check("rej_last_we", {31'd0, bus.imem_we}, 32'd0);
      check("rej_last_done", {31'd0, bus.done}, 32'd1);
      check("rej_last_count", 32'(bus.count), 32'd0);
      idle();

      // Session 4: fill DEPTH words, fifth bundle must stall
      start_pulse();
      for (int k = 1; k <= DEP; k++) begin
         push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(k), 1'b0);
         chk_wr("fill", BASE + 32'(4 * (k - 1)), (32'(k) << 20) | 32'h93);
      end
      check("full_done", {31'd0, bus.done}, 32'd1);
      check("full_ready", {31'd0, bus.in_ready}, 32'd0);
      check("full_count", 32'(bus.count), 32'(DEP));
      bus.in_imm   = 32'd9;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("full_no_we", {31'd0, bus.imem_we}, 32'd0);
         check("full_hold_count", 32'(bus.count), 32'(DEP));
      end
      idle();
      start_pulse();
      push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 1'b0);
      chk_wr("restart", BASE, 32'h0070_0093);
      check("restart_count", 32'(bus.count), 32'd1);

      // Reset during an accepting cycle drops the write and clears the session
      push(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 1'b0);
      check("pre_rst_err", {31'd0, bus.err}, 32'd1);
      bus.in_imm   = 32'd1;
      bus.in_valid = 1'b1;
      rst          = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("mrst_we", {31'd0, bus.imem_we}, 32'd0);
      check("mrst_busy", {31'd0, bus.busy}, 32'd0);
      check("mrst_done", {31'd0, bus.done}, 32'd0);
      check("mrst_count", 32'(bus.count), 32'd0);
      check("mrst_err", {31'd0, bus.err}, 32'd0);
      check("mrst_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("mrst_we_next", {31'd0, bus.imem_we}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
